// File: rtl/ramwriter_multi_if.sv
// ramwriter_multi_if: RAM write-port bus (data, address, byte enables, write strobe)
interface ramwriter_multi_if #(
  parameter int DW = 64,
  parameter int AW = 14
) ();
  logic [DW-1:0]   data;
  logic [AW-1:0]   address;
  logic [DW/8-1:0] byteen;
  logic            wbit;
  modport master (output data, address, byteen, wbit);
  modport slave  (input  data, address, byteen, wbit);
endinterface

// File: rtl/ramwriter_multi.sv
// ramwriter_multi: writes one packed multi-lane sample word per sample period into a RAM write port,
// with start/abort, external-data mode, stop-or-wrap addressing and capture status.
module ramwriter_multi #(
  parameter int CHANNELS      = 4,
  parameter int CH_WIDTH      = 16,
  parameter int ADDR_WIDTH    = 14,
  parameter int DEPTH         = 8192,
  parameter int SAMPLE_PERIOD = 500000,
  parameter int INIT_DELAY    = 5,
  parameter bit WRAP          = 1'b0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic                         i_use_ext,
  input  logic [CHANNELS*CH_WIDTH-1:0] i_ext_data,
  ramwriter_multi_if.master            ram,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_wrapped,
  output logic [ADDR_WIDTH:0]          o_wr_count
);
  localparam int DW = CHANNELS * CH_WIDTH;
  typedef enum logic [2:0] {IDLE, INIT, WRITE, WAIT, DONE} state_t;
  function automatic logic [DW-1:0] init_pat();
    logic [DW-1:0] p;
    p = '0;
    for (int k = 0; k < CHANNELS; k++) p[k*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'(k);
    return p;
  endfunction
  localparam logic [DW-1:0] PAT0 = init_pat();
  state_t                r_state;
  logic [31:0]           r_cnt;
  logic [DW-1:0]         r_pat;
  logic [DW-1:0]         r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wbit;
  logic [DW-1:0]         w_pat_nxt;
  logic [DW-1:0]         w_src;
  logic                  w_last;
  always_comb begin
    w_pat_nxt = r_pat;
    for (int k = 0; k < CHANNELS; k++)
      w_pat_nxt[k*CH_WIDTH +: CH_WIDTH] = r_pat[k*CH_WIDTH +: CH_WIDTH] + CH_WIDTH'(CHANNELS);
  end
  assign w_src  = i_use_ext ? i_ext_data : r_pat;
  assign w_last = r_addr == ADDR_WIDTH'(DEPTH - 1);
  assign ram.data    = r_data;
  assign ram.address = r_addr;
  assign ram.byteen  = '1;
  assign ram.wbit    = r_wbit;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pat      <= PAT0;
      r_data     <= PAT0;
      r_addr     <= '0;
      r_wbit     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_wrapped  <= 1'b0;
      o_wr_count <= '0;
    end else if (i_abort) begin
      r_state <= IDLE;
      r_wbit  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (i_start) begin
          r_state    <= INIT;
          r_cnt      <= '0;
          r_pat      <= PAT0;
          r_addr     <= '0;
          o_busy     <= 1'b1;
          o_done     <= 1'b0;
          o_wrapped  <= 1'b0;
          o_wr_count <= '0;
        end
        INIT, WAIT: begin
          // WAIT lasts SAMPLE_PERIOD-1 cycles so strobes land SAMPLE_PERIOD apart
          if (r_cnt == (r_state == INIT ? 32'(INIT_DELAY - 1) : 32'(SAMPLE_PERIOD - 2))) begin
            r_state <= WRITE;
            r_wbit  <= 1'b1;
            r_data  <= w_src;
          end else r_cnt <= r_cnt + 32'd1;
        end
        WRITE: begin
          r_wbit     <= 1'b0;
          r_pat      <= w_pat_nxt;
          r_cnt      <= '0;
          o_wr_count <= &o_wr_count ? o_wr_count : o_wr_count + 1'b1;
          if (w_last && !WRAP) begin
            r_state <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_state <= WAIT;
            r_addr  <= w_last ? '0 : r_addr + 1'b1;
            if (w_last) o_wrapped <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ramwriter_multi.sv
// tb_ramwriter_multi: directed checks of a stop-mode and a wrap-mode ramwriter_multi instance.
module tb_ramwriter_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, start_w = 1'b0, abort_w = 1'b0, use_ext = 1'b0;
  logic [63:0] ext = '0;
  logic        busy, done, wrapped, busy_w, done_w, wrapped_w;
  logic [4:0]  cnt, cnt_w;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  ramwriter_multi_if #(.DW(64), .AW(4)) bus ();
  ramwriter_multi_if #(.DW(64), .AW(4)) bus_w ();
  ramwriter_multi #(.CHANNELS(4), .CH_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(8), .SAMPLE_PERIOD(4),
    .INIT_DELAY(5), .WRAP(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_use_ext(use_ext),
    .i_ext_data(ext), .ram(bus.master), .o_busy(busy), .o_done(done), .o_wrapped(wrapped),
    .o_wr_count(cnt));
  ramwriter_multi #(.CHANNELS(4), .CH_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(8), .SAMPLE_PERIOD(4),
    .INIT_DELAY(5), .WRAP(1'b1)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w), .i_abort(abort_w), .i_use_ext(1'b0),
    .i_ext_data(ext), .ram(bus_w.master), .o_busy(busy_w), .o_done(done_w), .o_wrapped(wrapped_w),
    .o_wr_count(cnt_w));

  task automatic wait_strobe(input bit w, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(w ? bus_w.wbit : bus.wbit) && n < 40);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.wbit, busy, done, wrapped, cnt, bus.address} !== '0) begin
      failures++;
      $display("FAIL reset_state got wbit=%b busy=%b done=%b wrapped=%b cnt=%0d addr=%0d want all 0",
        bus.wbit, busy, done, wrapped, cnt, bus.address);
    end
    checks++;
    if (bus.byteen !== 8'hFF || bus.data !== 64'h0003_0002_0001_0000) begin
      failures++;
      $display("FAIL reset_bus got byteen=%h data=%h want ff 0003000200010000", bus.byteen, bus.data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_write();
    int n;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bus.wbit !== 1'b0) begin
      failures++;
      $display("FAIL start_busy got busy=%b wbit=%b want 1 0", busy, bus.wbit);
    end
    wait_strobe(1'b0, n);
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL init_latency got %0d edges want 5", n);
    end
    checks++;
    if (bus.address !== 4'd0 || bus.data !== 64'h0003_0002_0001_0000 || bus.byteen !== 8'hFF) begin
      failures++;
      $display("FAIL first_write got addr=%0d data=%h byteen=%h want 0 0003000200010000 ff",
        bus.address, bus.data, bus.byteen);
    end
  endtask

  task automatic test_full_capture();
    int n;
    for (int i = 1; i < 8; i++) begin
      wait_strobe(1'b0, n);
      checks++;
      if (n !== 4 || bus.address !== 4'(i)) begin
        failures++;
        $display("FAIL strobe_%0d got gap=%0d addr=%0d want 4 %0d", i, n, bus.address, i);
      end
    end
    checks++;
    if (bus.data !== 64'h001F_001E_001D_001C) begin
      failures++;
      $display("FAIL last_data got %h want 001f001e001d001c", bus.data);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== 5'd8 || bus.address !== 4'd7) begin
      failures++;
      $display("FAIL capture_done got done=%b busy=%b cnt=%0d addr=%0d want 1 0 8 7",
        done, busy, cnt, bus.address);
    end
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.wbit) n++;
    end
    checks++;
    if (n !== 0 || done !== 1'b1) begin
      failures++;
      $display("FAIL done_quiet got strobes=%0d done=%b want 0 1", n, done);
    end
  endtask

  task automatic test_ext_data();
    int n;
    ext = 64'hDEAD_BEEF_0123_4567;
    use_ext = 1'b1;
    pulse_start();
    wait_strobe(1'b0, n);
    checks++;
    if (bus.data !== ext || bus.address !== 4'd0) begin
      failures++;
      $display("FAIL ext_strobe_0 got data=%h addr=%0d want deadbeef01234567 0", bus.data, bus.address);
    end
    pulse_start();
    for (int i = 1; i < 3; i++) begin
      wait_strobe(1'b0, n);
      checks++;
      if (bus.data !== ext || bus.address !== 4'(i) || n !== (i == 1 ? 3 : 4)) begin
        failures++;
        $display("FAIL ext_strobe_%0d got data=%h addr=%0d gap=%0d", i, bus.data, bus.address, n);
      end
    end
    use_ext = 1'b0;
    wait_strobe(1'b0, n);
    checks++;
    if (bus.data !== 64'h000F_000E_000D_000C || bus.address !== 4'd3) begin
      failures++;
      $display("FAIL ext_switch_back got data=%h addr=%0d want 000f000e000d000c 3", bus.data, bus.address);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.wbit !== 1'b0) begin
      failures++;
      $display("FAIL ext_abort got busy=%b wbit=%b want 0 0", busy, bus.wbit);
    end
  endtask

  task automatic test_abort();
    int n;
    pulse_start();
    repeat (3) wait_strobe(1'b0, n);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (bus.wbit !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.address !== 4'd2 || cnt !== 5'd2) begin
      failures++;
      $display("FAIL abort_state got wbit=%b busy=%b done=%b addr=%0d cnt=%0d want 0 0 0 2 2",
        bus.wbit, busy, done, bus.address, cnt);
    end
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.wbit) n++;
    end
    checks++;
    if (n !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet got strobes=%0d busy=%b want 0 0", n, busy);
    end
    pulse_start();
    wait_strobe(1'b0, n);
    checks++;
    if (bus.address !== 4'd0 || bus.data !== 64'h0003_0002_0001_0000 || n !== 5) begin
      failures++;
      $display("FAIL abort_restart got addr=%0d data=%h lat=%0d want 0 0003000200010000 5",
        bus.address, bus.data, n);
    end
  endtask

  task automatic test_wrap();
    int n;
    bit  saw_done;
    logic [3:0] want;
    saw_done = 1'b0;
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_strobe(1'b1, n);
      saw_done |= done_w;
      want = 4'(i % 8);
      checks++;
      if (bus_w.address !== want) begin
        failures++;
        $display("FAIL wrap_addr_%0d got %0d want %0d", i, bus_w.address, want);
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (wrapped_w !== (i == 8)) begin
          failures++;
          $display("FAIL wrap_flag_%0d got %b want %b", i, wrapped_w, i == 8);
        end
      end
    end
    checks++;
    if (saw_done || done_w !== 1'b0 || busy_w !== 1'b1) begin
      failures++;
      $display("FAIL wrap_no_done got done_seen=%b busy=%b want 0 1", saw_done, busy_w);
    end
    abort_w = 1'b1;
    @(negedge clk);
    abort_w = 1'b0;
  endtask

  task automatic test_reset_midwrite();
    int n;
    pulse_start();
    wait_strobe(1'b0, n);
    checks++;
    if (bus.wbit !== 1'b1) begin
      failures++;
      $display("FAIL midwrite_setup got wbit=%b want 1", bus.wbit);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wbit !== 1'b0 || busy !== 1'b0 || bus.byteen !== 8'hFF || bus.address !== 4'd0) begin
      failures++;
      $display("FAIL async_reset got wbit=%b busy=%b byteen=%h addr=%0d want 0 0 ff 0",
        bus.wbit, busy, bus.byteen, bus.address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_full_capture();
    test_ext_data();
    test_abort();
    test_wrap();
    test_reset_midwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
